// File: rtl/alu_share_arb.sv
// Round-robin arbiter with a 2-stage issue/result pipeline in front of one shared ALU.
// Optional per-requester saturating grant counters are enabled by ALU_ARB_STATS_EN.
module alu_share_arb #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  input  logic [4*NREQ-1:0]    req_op,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  output logic [3:0]           alu_op,
  input  logic [31:0]          alu_result,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_data,
  output logic                 busy,
  output logic [16*NREQ-1:0]   grant_cnt
);

  localparam int unsigned DW  = 32;
  localparam int unsigned OPW = 4;
  localparam int unsigned CW  = 16;

  logic            r_s1_valid;
  logic [DW-1:0]   r_s1_a;
  logic [DW-1:0]   r_s1_b;
  logic [OPW-1:0]  r_s1_op;
  logic [IDW-1:0]  r_s1_id;
  logic            r_s2_valid;
  logic [DW-1:0]   r_s2_data;
  logic [IDW-1:0]  r_s2_id;
  logic [IDW-1:0]  r_last;

  logic            w_adv1;
  logic            w_adv2;
  logic            w_found;
  logic [IDW-1:0]  w_grant;
  logic            w_accept;
  logic [DW-1:0]   w_sel_a;
  logic [DW-1:0]   w_sel_b;
  logic [OPW-1:0]  w_sel_op;

  assign w_adv2 = !r_s2_valid || rsp_ready;
  assign w_adv1 = !r_s1_valid || w_adv2;

  // Rotating priority search starting just after the last winner.
  always_comb begin
    logic [IDW-1:0] idx;
    w_found = 1'b0;
    w_grant = r_last;
    idx     = '0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      idx = IDW'((int'(r_last) + k) % int'(NREQ));
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_grant = idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      req_ready[i] = !reset && w_adv1 && w_found && (w_grant == IDW'(i)) && req_valid[i];
    end
  end

  assign w_accept = |req_ready;

  // Winner operand mux feeding the S1 registers only.
  always_comb begin
    w_sel_a  = '0;
    w_sel_b  = '0;
    w_sel_op = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (w_grant == IDW'(i)) begin
        w_sel_a  = req_a[DW*i +: DW];
        w_sel_b  = req_b[DW*i +: DW];
        w_sel_op = req_op[OPW*i +: OPW];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_op    <= '0;
      r_s1_id    <= '0;
      r_last     <= IDW'(NREQ - 1);
    end else if (w_adv1) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_a  <= w_sel_a;
        r_s1_b  <= w_sel_b;
        r_s1_op <= w_sel_op;
        r_s1_id <= w_grant;
        r_last  <= w_grant;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_id    <= '0;
    end else if (w_adv2) begin
      r_s2_valid <= r_s1_valid;
      r_s2_data  <= alu_result;
      r_s2_id    <= r_s1_id;
    end
  end

  assign alu_a     = r_s1_a;
  assign alu_b     = r_s1_b;
  assign alu_op    = r_s1_op;
  assign rsp_valid = r_s2_valid;
  assign rsp_data  = r_s2_data;
  assign rsp_id    = r_s2_id;
  assign busy      = r_s1_valid || r_s2_valid;

`ifdef ALU_ARB_STATS_EN
  logic [CW-1:0] r_cnt [NREQ];

  // Saturating per-requester accept counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NREQ); i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (req_ready[i] && (r_cnt[i] != '1)) r_cnt[i] <= r_cnt[i] + CW'(1);
      end
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_cnt
    assign grant_cnt[CW*g +: CW] = r_cnt[g];
  end
`else
  assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed self-checking bench for alu_share_arb (2- and 3-requester instances).
module tb_alu_share_arb;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [1:0]  req_valid, req_ready;
  logic [63:0] req_a, req_b;
  logic [7:0]  req_op;
  logic [31:0] alu_a, alu_b, alu_result, rsp_data;
  logic [3:0]  alu_op;
  logic        rsp_valid, rsp_ready, busy;
  logic        rsp_id;
  logic [31:0] grant_cnt;

  logic [2:0]  req_valid3, req_ready3;
  logic [95:0] req_a3, req_b3;
  logic [11:0] req_op3;
  logic [31:0] alu_a3, alu_b3, alu_result3, rsp_data3;
  logic [3:0]  alu_op3;
  logic        rsp_valid3, rsp_ready3, busy3;
  logic [1:0]  rsp_id3;
  logic [47:0] grant_cnt3;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural stand-in for the shared ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor.
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      default: return 32'h0;
    endcase
  endfunction

  assign alu_result  = alu_f(alu_a, alu_b, alu_op);
  assign alu_result3 = alu_f(alu_a3, alu_b3, alu_op3);

  alu_share_arb #(.NREQ(2)) u_dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy), .grant_cnt(grant_cnt)
  );

  alu_share_arb #(.NREQ(3)) u_dut3 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid3), .req_ready(req_ready3),
    .req_a(req_a3), .req_b(req_b3), .req_op(req_op3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3), .alu_result(alu_result3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_id(rsp_id3), .rsp_data(rsp_data3),
    .busy(busy3), .grant_cnt(grant_cnt3)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    req_valid = '0; req_valid3 = '0;
    rsp_ready = 1'b1; rsp_ready3 = 1'b1;
    tick; tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    req_valid = 2'b11; req_valid3 = 3'b111;
    req_a = '0; req_b = '0; req_op = '0;
    req_a3 = '0; req_b3 = '0; req_op3 = '0;
    rsp_ready = 1'b1; rsp_ready3 = 1'b1;
    #2;
    n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL reset_ready got %b want 00", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (alu_a !== 32'h0 || alu_b !== 32'h0 || alu_op !== 4'h0) begin n_bad++; $display("FAIL reset_alu got %h/%h/%h want 0", alu_a, alu_b, alu_op); end
    n_cmp++; if (rsp_id !== 1'b0 || rsp_data !== 32'h0) begin n_bad++; $display("FAIL reset_rsp got id %h data %h want 0", rsp_id, rsp_data); end
    do_reset;
  endtask

  task automatic test_single;
    do_reset;
    req_valid = 2'b01; req_a[31:0] = 32'h5; req_b[31:0] = 32'h3; req_op[3:0] = 4'd0;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL single_ready got %b want 01", req_ready); end
    tick;
    req_valid = 2'b00;
    #1;
    n_cmp++; if (alu_a !== 32'h5 || alu_b !== 32'h3) begin n_bad++; $display("FAIL single_alu got %h/%h want 5/3", alu_a, alu_b); end
    n_cmp++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL single_c1 got busy %b rsp_valid %b want 1/0", busy, rsp_valid); end
    tick; #1;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 32'h8) begin n_bad++; $display("FAIL single_rsp got v%b id%h d%h want v1 id0 d8", rsp_valid, rsp_id, rsp_data); end
    tick; #1;
    n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL single_idle got v%b busy%b want 0/0", rsp_valid, busy); end
  endtask

  task automatic test_reset_mid;
    do_reset;
    req_valid = 2'b01; req_a[31:0] = 32'd7; req_b[31:0] = 32'd9; req_op[3:0] = 4'd0;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL rmid_ready got %b want 01", req_ready); end
    tick;
    req_valid = 2'b00;
    #1;
    n_cmp++; if (alu_a !== 32'd7) begin n_bad++; $display("FAIL rmid_pre_alu got %h want 7", alu_a); end
    reset = 1'b1;
    #1;
    n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || alu_a !== 32'h0) begin n_bad++; $display("FAIL rmid_async got v%b busy%b a%h want 0/0/0", rsp_valid, busy, alu_a); end
    tick;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rmid_dropped c%0d got v%b busy%b want 0/0", k, rsp_valid, busy); end
      tick;
    end
    req_valid = 2'b11;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL rmid_first_grant got %b want 01", req_ready); end
    tick;
    req_valid = 2'b00;
    tick; tick;
  endtask

  task automatic test_round_robin;
    logic [1:0]  exp_rdy;
    logic [31:0] exp_d;
    do_reset;
    req_a = {32'd20, 32'd10}; req_b = {32'd2, 32'd1}; req_op = {4'd1, 4'd0};
    req_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      #1;
      exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
      n_cmp++; if (req_ready !== exp_rdy) begin n_bad++; $display("FAIL rr_grant c%0d got %b want %b", k, req_ready, exp_rdy); end
      if (k >= 2) begin
        exp_d = (k % 2 == 0) ? 32'd11 : 32'd18;
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'(k % 2) || rsp_data !== exp_d) begin
          n_bad++; $display("FAIL rr_rsp c%0d got v%b id%h d%h want v1 id%0d d%h", k, rsp_valid, rsp_id, rsp_data, k % 2, exp_d);
        end
      end
      tick;
    end
    req_valid = 2'b00;
    tick; tick;
  endtask

  task automatic test_backpressure;
    do_reset;
    rsp_ready = 1'b0;
    req_valid = 2'b01; req_a[31:0] = 32'd1; req_b[31:0] = 32'd1; req_op = 8'h00;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL bp_acc1 got %b want 01", req_ready); end
    tick;
    req_valid = 2'b10; req_a[63:32] = 32'd2; req_b[63:32] = 32'd2;
    #1;
    n_cmp++; if (req_ready !== 2'b10 || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_acc2 got rdy %b v%b want 10/0", req_ready, rsp_valid); end
    tick;
    req_valid = 2'b01; req_a[31:0] = 32'd3; req_b[31:0] = 32'd3;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++;
      if (req_ready !== 2'b00 || rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 32'd2 || busy !== 1'b1) begin
        n_bad++; $display("FAIL bp_hold c%0d got rdy %b v%b id%h d%h busy%b want 00 1 0 2 1", k, req_ready, rsp_valid, rsp_id, rsp_data, busy);
      end
      tick;
    end
    rsp_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 2'b01 || rsp_data !== 32'd2) begin n_bad++; $display("FAIL bp_release got rdy %b d%h want 01/2", req_ready, rsp_data); end
    tick;
    req_valid = 2'b00;
    #1;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 32'd4) begin n_bad++; $display("FAIL bp_rsp2 got v%b id%h d%h want 1/1/4", rsp_valid, rsp_id, rsp_data); end
    tick; #1;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 32'd6) begin n_bad++; $display("FAIL bp_rsp3 got v%b id%h d%h want 1/0/6", rsp_valid, rsp_id, rsp_data); end
    tick; #1;
    n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL bp_drain got v%b busy%b want 0/0", rsp_valid, busy); end
  endtask

  task automatic test_wrap;
    logic [2:0] exp_rdy;
    do_reset;
    req_a3 = {32'd200, 32'd5, 32'd100};
    req_b3 = {32'd50, 32'd3, 32'd1};
    req_op3 = {4'd1, 4'd2, 4'd0};
    req_valid3 = 3'b101;
    for (int k = 0; k < 4; k++) begin
      #1;
      exp_rdy = (k % 2 == 0) ? 3'b001 : 3'b100;
      n_cmp++; if (req_ready3 !== exp_rdy) begin n_bad++; $display("FAIL wrap_grant c%0d got %b want %b", k, req_ready3, exp_rdy); end
      if (k == 2) begin
        n_cmp++; if (rsp_valid3 !== 1'b1 || rsp_id3 !== 2'd0 || rsp_data3 !== 32'd101) begin n_bad++; $display("FAIL wrap_rsp0 got v%b id%h d%h want 1/0/101", rsp_valid3, rsp_id3, rsp_data3); end
      end
      if (k == 3) begin
        n_cmp++; if (rsp_valid3 !== 1'b1 || rsp_id3 !== 2'd2 || rsp_data3 !== 32'd150) begin n_bad++; $display("FAIL wrap_rsp2 got v%b id%h d%h want 1/2/150", rsp_valid3, rsp_id3, rsp_data3); end
      end
      tick;
    end
    req_valid3 = 3'b010;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (req_ready3 !== 3'b010) begin n_bad++; $display("FAIL single_req_grant c%0d got %b want 010", k, req_ready3); end
      tick;
    end
    req_valid3 = 3'b000;
    tick; tick;
    #1;
    n_cmp++; if (rsp_valid3 !== 1'b0 || busy3 !== 1'b0) begin n_bad++; $display("FAIL wrap_drain got v%b busy%b want 0/0", rsp_valid3, busy3); end
  endtask

  task automatic test_stats;
`ifdef ALU_ARB_STATS_EN
    do_reset;
    req_valid = 2'b10;
    repeat (3) tick;
    n_cmp++; if (grant_cnt[31:16] !== 16'd3 || grant_cnt[15:0] !== 16'd0) begin n_bad++; $display("FAIL stats_count3 got %h want 0003_0000", grant_cnt); end
    repeat (69997) tick;
    n_cmp++; if (grant_cnt[31:16] !== 16'hFFFF) begin n_bad++; $display("FAIL stats_sat got %h want ffff", grant_cnt[31:16]); end
    n_cmp++; if (grant_cnt[15:0] !== 16'h0) begin n_bad++; $display("FAIL stats_req0 got %h want 0", grant_cnt[15:0]); end
    req_valid = 2'b00;
`else
    n_cmp++; if (grant_cnt !== 32'h0) begin n_bad++; $display("FAIL stats_off got %h want 0", grant_cnt); end
    n_cmp++; if (grant_cnt3 !== 48'h0) begin n_bad++; $display("FAIL stats_off3 got %h want 0", grant_cnt3); end
`endif
  endtask

  initial begin
    test_reset;
    test_single;
    test_reset_mid;
    test_round_robin;
    test_backpressure;
    test_wrap;
    test_stats;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
